// File: rtl/rx_pkg.sv
// Shared constants and types for the frame-buffer port arbiter.
// Covers the memory geometry, fill burst length, fill FSM encoding and the FIFO entry layout.
package rx_pkg;
    localparam int AW         = 16;
    localparam int DW         = 12;
    localparam int FIFO_DEPTH = 4;

    localparam logic [AW-1:0] MEM_WORDS = 16'h9600;
    localparam logic [AW-1:0] MEM_LAST  = 16'h95FF;
    localparam logic [6:0]    LINE_LAST = 7'd79;   // LINE_WORDS - 1

    typedef enum logic {
        FILL_IDLE = 1'b0,
        FILL_RUN  = 1'b1
    } fill_state_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_entry_t;
endpackage

// File: rtl/fb_wr_fifo.sv
// Small synchronous FIFO that buffers live Rx writes.
// Push is ignored when full and pop is ignored when empty.
module fb_wr_fifo #(
    parameter int W     = 28,
    parameter int DEPTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_push,
    input  logic [W-1:0]           i_wdata,
    input  logic                   i_pop,
    output logic [W-1:0]           o_rdata,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [PW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = (r_count == (PW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rptr];

    // Storage carries no reset; emptiness is tracked entirely by the pointers and count.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/fb_port_arbiter.sv
// Frame-buffer port arbiter: reads first, then buffered Rx writes, then zero-fill bursts.
// The memory port is driven combinationally from the grant; read data returns two cycles after the grant.
module fb_port_arbiter
    import rx_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_rst,
    // Rx write handshake: a write transfers on a cycle where i_wr_valid && o_wr_ready;
    // a write offered while o_wr_ready is low is lost and sets o_ovf.
    input  logic          i_wr_valid,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [DW-1:0] i_wr_data,
    output logic          o_wr_ready,
    input  logic          i_fill_req,
    input  logic [AW-1:0] i_fill_addr,
    output logic          o_fill_busy,
    input  logic          i_rd_req,
    input  logic [AW-1:0] i_rd_addr,
    output logic [DW-1:0] o_rd_data,
    output logic          o_rd_valid,
    output logic          o_mem_en,
    output logic          o_mem_we,
    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_wdata,
    input  logic [DW-1:0] i_mem_rdata,
    output logic          o_ovf,
    output logic          o_drop,
    output fill_state_t   o_dbg_fill_state
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    wr_entry_t     w_head;
    logic [CW-1:0] w_count;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_head_oob;
    logic          w_gnt_rd;
    logic          w_gnt_wr;
    logic          w_gnt_fill;

    fill_state_t   r_state;
    fill_state_t   w_state_nxt;
    logic [AW-1:0] r_fptr;
    logic [AW-1:0] w_fptr_nxt;
    logic [6:0]    r_fcnt;
    logic [6:0]    w_fcnt_nxt;

    logic          r_rd_p1;
    logic          r_rd_valid;
    logic [DW-1:0] r_rd_data;
    logic          r_ovf;
    logic          r_drop;

    assign o_wr_ready = (w_count < CW'(FIFO_DEPTH));
    assign w_push     = i_wr_valid && o_wr_ready;

    fb_wr_fifo #(
        .W     ($bits(wr_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_wdata ({i_wr_addr, i_wr_data}),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // An out-of-range head is still popped on its slot, so it costs a cycle but never reaches memory.
    assign w_head_oob = (w_head.addr >= MEM_WORDS);
    assign w_gnt_rd   = i_rd_req;
    assign w_pop      = !i_rd_req && !w_empty;
    assign w_gnt_wr   = w_pop && !w_head_oob;
    assign w_gnt_fill = !i_rd_req && w_empty && (r_state == FILL_RUN);

    always_comb begin
        o_mem_en    = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        if (w_gnt_rd) begin
            o_mem_en   = 1'b1;
            o_mem_addr = i_rd_addr;
        end else if (w_gnt_wr) begin
            o_mem_en    = 1'b1;
            o_mem_we    = 1'b1;
            o_mem_addr  = w_head.addr;
            o_mem_wdata = w_head.data;
        end else if (w_gnt_fill) begin
            o_mem_en   = 1'b1;
            o_mem_we   = 1'b1;
            o_mem_addr = r_fptr;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_fptr_nxt  = r_fptr;
        w_fcnt_nxt  = r_fcnt;
        case (r_state)
            FILL_IDLE: begin
                if (i_fill_req && (i_fill_addr < MEM_WORDS)) begin
                    w_state_nxt = FILL_RUN;
                    w_fptr_nxt  = i_fill_addr;
                    w_fcnt_nxt  = '0;
                end
            end
            FILL_RUN: begin
                if (w_gnt_fill) begin
                    w_fptr_nxt = r_fptr + AW'(1);
                    w_fcnt_nxt = r_fcnt + 7'd1;
                    // Bursts stop at the end of memory rather than wrapping.
                    if ((r_fcnt == LINE_LAST) || (r_fptr == MEM_LAST)) begin
                        w_state_nxt = FILL_IDLE;
                    end
                end
            end
            default: w_state_nxt = FILL_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= FILL_IDLE;
            r_fptr     <= '0;
            r_fcnt     <= '0;
            r_rd_p1    <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_ovf      <= 1'b0;
            r_drop     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_fptr     <= w_fptr_nxt;
            r_fcnt     <= w_fcnt_nxt;
            r_rd_p1    <= w_gnt_rd;
            r_rd_valid <= r_rd_p1;
            if (r_rd_p1) begin
                r_rd_data <= i_mem_rdata;
            end
            r_ovf  <= r_ovf | (i_wr_valid && w_full);
            r_drop <= r_drop | (w_pop && w_head_oob);
        end
    end

    assign o_fill_busy      = (r_state == FILL_RUN);
    assign o_rd_valid       = r_rd_valid;
    assign o_rd_data        = r_rd_data;
    assign o_ovf            = r_ovf;
    assign o_drop           = r_drop;
    assign o_dbg_fill_state = r_state;
endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench for fb_port_arbiter with a behavioural frame memory.
// Expected memory writes and read returns are queued at issue time and checked by a negedge monitor.
module tb_fb_port_arbiter;
    import rx_pkg::*;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_valid = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_ready;
    logic          fill_req = 1'b0;
    logic [AW-1:0] fill_addr = '0;
    logic          fill_busy;
    logic          rd_req = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          ovf;
    logic          drop;
    fill_state_t   dbg_state;

    logic [DW-1:0]     mem [0:38399];
    logic [AW+DW-1:0]  exp_wr_q[$];
    logic [DW-1:0]     exp_rd_q[$];
    int                exp_rd_cyc_q[$];
    int                cyc = 0;
    int                n_vec = 0;
    int                n_err = 0;

    fb_port_arbiter dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_wr_valid       (wr_valid),
        .i_wr_addr        (wr_addr),
        .i_wr_data        (wr_data),
        .o_wr_ready       (wr_ready),
        .i_fill_req       (fill_req),
        .i_fill_addr      (fill_addr),
        .o_fill_busy      (fill_busy),
        .i_rd_req         (rd_req),
        .i_rd_addr        (rd_addr),
        .o_rd_data        (rd_data),
        .o_rd_valid       (rd_valid),
        .o_mem_en         (mem_en),
        .o_mem_we         (mem_we),
        .o_mem_addr       (mem_addr),
        .o_mem_wdata      (mem_wdata),
        .i_mem_rdata      (mem_rdata),
        .o_ovf            (ovf),
        .o_drop           (drop),
        .o_dbg_fill_state (dbg_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                if (mem_addr < 16'h9600) mem[mem_addr] <= mem_wdata;
            end else begin
                mem_rdata <= mem[mem_addr];
            end
        end
    end

    // Monitor: every memory write and every read return must match the head of its queue.
    always @(negedge clk) begin
        logic [AW+DW-1:0] e;
        int               ec;
        if (!rst) begin
            if (mem_en && mem_we) begin
                n_vec++;
                if (exp_wr_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_write: got addr=%h data=%h, required no write", mem_addr, mem_wdata);
                end else begin
                    e = exp_wr_q.pop_front();
                    if ({mem_addr, mem_wdata} !== e) begin
                        n_err++;
                        $display("FAIL mem_write: got addr=%h data=%h, required addr=%h data=%h",
                                 mem_addr, mem_wdata, e[AW+DW-1:DW], e[DW-1:0]);
                    end
                end
            end
            if (rd_valid) begin
                n_vec++;
                if (exp_rd_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_rd_valid: got data=%h, required no return", rd_data);
                end else begin
                    e  = {{AW{1'b0}}, exp_rd_q.pop_front()};
                    ec = exp_rd_cyc_q.pop_front();
                    if (rd_data !== e[DW-1:0] || cyc != ec) begin
                        n_err++;
                        $display("FAIL rd_return: got data=%h cycle=%0d, required data=%h cycle=%0d",
                                 rd_data, cyc, e[DW-1:0], ec);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic issue_read(input logic [AW-1:0] a, input logic [DW-1:0] d);
        rd_req  = 1'b1;
        rd_addr = a;
        exp_rd_q.push_back(d);
        exp_rd_cyc_q.push_back(cyc + 2);
    endtask

    task automatic wait_wr_empty(input string name, input int budget);
        int k = 0;
        while (exp_wr_q.size() != 0 && k < budget) begin
            step();
            k++;
        end
        chk(name, exp_wr_q.size(), 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_wr_ready"}, wr_ready, 1);
        chk({tag, "_fill_busy"}, fill_busy, 0);
        chk({tag, "_rd_valid"}, rd_valid, 0);
        chk({tag, "_rd_data"}, rd_data, 0);
        chk({tag, "_mem_en"}, mem_en, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_ovf"}, ovf, 0);
        chk({tag, "_drop"}, drop, 0);
    endtask

    // Fill burst from a with exp_words hand-computed zero writes; optionally re-pulse mid-burst.
    task automatic run_fill(input logic [AW-1:0] a, input int exp_words, input bit mid_pulse);
        int busy = 0;
        for (int i = 0; i < exp_words; i++) exp_wr_q.push_back({a + 16'(i), 12'h000});
        fill_req  = 1'b1;
        fill_addr = a;
        step();
        for (int c = 0; c < 120; c++) begin
            if (mid_pulse && c == 10) begin
                fill_req  = 1'b1;
                fill_addr = 16'h0300;
            end else begin
                fill_req = 1'b0;
            end
            @(negedge clk);
            if (fill_busy) busy++;
            step();
        end
        chk("fill_busy_cycles", busy, exp_words);
        chk("fill_writes_done", exp_wr_q.size(), 0);
        chk("fill_state_idle", dbg_state, FILL_IDLE);
    endtask

    initial begin
        logic [DW-1:0] wd [4];
        wd = '{12'h111, 12'h222, 12'h333, 12'h444};
        mem[16'h0000] = 12'hABC;
        mem[16'h0001] = 12'h123;
        mem[16'h0014] = 12'h000;
        mem[16'h0020] = 12'h555;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        step();
        rst = 1'b0;
        step();

        // Back-to-back reads.
        issue_read(16'h0000, 12'hABC);
        step();
        issue_read(16'h0001, 12'h123);
        step();
        rd_req = 1'b0;
        repeat (4) step();
        chk("read_returns_done", exp_rd_q.size(), 0);

        // Four writes stalled behind continuous reads, then a fifth while full.
        for (int i = 0; i < 4; i++) begin
            issue_read(16'h0020, 12'h555);
            wr_valid = 1'b1;
            wr_addr  = 16'h0010 + 16'(i);
            wr_data  = wd[i];
            exp_wr_q.push_back({wr_addr, wr_data});
            step();
        end
        issue_read(16'h0020, 12'h555);
        wr_addr = 16'h0014;
        wr_data = 12'hEEE;
        @(negedge clk);
        chk("wr_ready_full", wr_ready, 0);
        chk("ovf_before", ovf, 0);
        step();
        wr_valid = 1'b0;
        rd_req   = 1'b0;
        @(negedge clk);
        chk("ovf_set", ovf, 1);
        step();
        wait_wr_empty("fifo_drain", 20);
        repeat (3) step();
        chk("wr_ready_after_drain", wr_ready, 1);
        chk("ovf_data_not_written", mem[16'h0014], 12'h000);
        chk("contention_reads_done", exp_rd_q.size(), 0);

        // Fill bursts: full line with ignored re-pulse, truncated at memory end, out of range.
        run_fill(16'h0050, 80, 1'b1);
        run_fill(16'h95F0, 16, 1'b0);
        run_fill(16'h9600, 0, 1'b0);

        // Priority mix: FIFO entry, active fill and a read all contend in one cycle.
        fill_req  = 1'b1;
        fill_addr = 16'h0100;
        wr_valid  = 1'b1;
        wr_addr   = 16'h0200;
        wr_data   = 12'h7A7;
        exp_wr_q.push_back({16'h0200, 12'h7A7});
        for (int i = 0; i < 80; i++) exp_wr_q.push_back({16'h0100 + 16'(i), 12'h000});
        step();
        fill_req = 1'b0;
        wr_valid = 1'b0;
        issue_read(16'h0020, 12'h555);
        @(negedge clk);
        chk("grant1_read", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, 16'h0020});
        step();
        rd_req = 1'b0;
        @(negedge clk);
        chk("grant2_write", {mem_en, mem_we, mem_addr}, {1'b1, 1'b1, 16'h0200});
        step();
        @(negedge clk);
        chk("grant3_fill", {mem_en, mem_we, mem_addr}, {1'b1, 1'b1, 16'h0100});
        step();
        wait_wr_empty("mix_fill_done", 120);
        step();
        chk("mix_fill_busy_low", fill_busy, 0);

        // Out-of-range live write: popped without a memory cycle, sets drop.
        wr_valid = 1'b1;
        wr_addr  = 16'h9600;
        wr_data  = 12'hFFF;
        step();
        wr_valid = 1'b0;
        @(negedge clk);
        chk("oob_no_mem_cycle", mem_en, 0);
        step();
        @(negedge clk);
        chk("drop_set", drop, 1);
        step();

        // Reset in the middle of a fill burst.
        for (int i = 0; i < 5; i++) exp_wr_q.push_back({16'h0400 + 16'(i), 12'h000});
        fill_req  = 1'b1;
        fill_addr = 16'h0400;
        step();
        fill_req = 1'b0;
        repeat (5) step();
        rst = 1'b1;
        #1;
        chk_reset_outputs("midfill_reset");
        chk("midfill_state", dbg_state, FILL_IDLE);
        repeat (2) step();
        rst = 1'b0;
        repeat (20) step();
        chk("midfill_writes", exp_wr_q.size(), 0);
        chk("post_reset_busy", fill_busy, 0);
        chk("final_rd_queue", exp_rd_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no completion, required finish before 100000ns");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/fb_port_arbiter.md
# fb_port_arbiter

Single-port frame-buffer access controller between the RF receive path and the HDMI pixel fetch. Three requesters share one 12-bit × 38400-word memory port: live Rx pixel writes (buffered in a small FIFO), line zero-fill bursts issued by the packet watchdog, and pixel reads. Reads always win, live writes drain next, and zero-fill uses the remaining cycles. The block drives the memory port directly and sits between the Rx deframer/watchdog and the frame memory.

## Interface
- AW, 16, address width
- DW, 12, data width (one packed pixel word)
- FIFO_DEPTH, 4, write FIFO entries (power of two)
- MEM_WORDS, 38400 (0x9600), valid addresses are 0..MEM_WORDS-1
- LINE_WORDS, 80 (0x50), words per zero-fill burst
- Cclk  in  1  system clock; the only clock
- rst  in  1  asynchronous, active-high reset
- wr_valid  in  1  Rx write request
- wr_addr  in  AW  Rx write address
- wr_data  in  DW  Rx write data
- wr_ready  out  1  FIFO can accept a write; reset 1
- fill_req  in  1  one-cycle pulse that starts a zero-fill burst
- fill_addr  in  AW  first address of the burst
- fill_busy  out  1  burst in progress; reset 0
- rd_req  in  1  pixel read request
- rd_addr  in  AW  read address
- rd_data  out  DW  read data; reset 0
- rd_valid  out  1  rd_data valid strobe; reset 0
- mem_en  out  1  memory port enable; reset 0
- mem_we  out  1  write enable; reset 0
- mem_addr  out  AW  port address; reset 0
- mem_wdata  out  DW  port write data; reset 0
- mem_rdata  in  DW  memory read data, valid 1 cycle after mem_en && !mem_we
- ovf  out  1  sticky: write lost to overflow; reset 0
- drop  out  1  sticky: out-of-range write discarded; reset 0

## Operation
- Write FIFO:
  - wr_ready = count < FIFO_DEPTH, computed from the registered count.
  - A write is accepted when wr_valid && wr_ready.
  - wr_valid && !wr_ready discards the write and sets ovf.
  - When full, an accept and a drain in the same cycle are impossible because ready is already low. When not full, they may coincide and count is unchanged.
- Range check at FIFO output: a head entry with addr ≥ MEM_WORDS is popped without a memory cycle and sets drop. This pop consumes the write slot.
- Fill FSM, two states:
  - IDLE: fill_req latches fill_addr into fptr, sets fcnt = 0, and moves to FILL. fill_busy = 1 from the next cycle.
  - FILL: each granted fill cycle writes 0 to fptr, then increments fptr and fcnt. Leave to IDLE after the grant where fcnt = LINE_WORDS-1, or after the grant where fptr = MEM_WORDS-1 (truncated burst, no wrap).
  - A fill_addr ≥ MEM_WORDS is ignored and the FSM stays in IDLE.
  - fill_req while in FILL is ignored.
- Per-cycle grant priority, fixed and non-rotating: (1) rd_req, (2) FIFO not empty, (3) FSM in FILL. With no requester, mem_en = 0.
- Memory port signals (mem_en, mem_we, mem_addr, mem_wdata) are combinational from the grant. No extra pipeline stage.
- Read return: rd_data is registered from mem_rdata. rd_valid is a 2-stage delay of the read grant.
- Ordering:
  - FIFO writes are issued in acceptance order.
  - A read to an address with a pending FIFO write returns the old data. This is accepted because the display tolerates a one-frame-stale pixel.
  - A fill and a live write to the same address resolve last-issued-wins.
- Reset mid-burst: the FSM returns to IDLE, the FIFO empties, and both sticky flags clear.

## Timing
- Read latency: rd_req at cycle N → mem_en at N → rd_valid/rd_data at N+2. Back-to-back reads are supported at one per cycle.
- Write latency: accept at N → earliest mem write at N+1 (FIFO registered). With rd_req asserted continuously, writes stall indefinitely. The upstream contract is at most 1 read per 5 cycles.
- Fill throughput: LINE_WORDS cycles minimum when uncontended. fill_busy deasserts the cycle after the last fill write.
- Sustained input: Rx at ≤1 write per 2 cycles plus reads at 1/5 never overflows a depth-4 FIFO.

## Structure
- Shared package (rx_pkg): AW, DW, MEM_WORDS, LINE_WORDS constants; fill FSM state encoding.
- One sub-module: fb_wr_fifo, a synchronous FIFO with count, full, empty, push and pop. The arbiter, fill FSM and read pipe live in the top module.

## Test plan
- Read-only: rd_req at addrs 0x0000, 0x0001 with mem preloaded 0xABC, 0x123 → rd_valid at N+2 and N+3 with rd_data 0xABC then 0x123.
- Write under read contention: 4 writes to 0x0010..0x0013 while rd_req is high every cycle → wr_ready = 0 after the 4th write, then all four writes appear in order once rd_req drops. A 5th wr_valid while full → ovf = 1 and that data is never written.
- Fill: fill_req with fill_addr 0x0050, no other traffic → 80 writes of 0 to 0x0050..0x009F, fill_busy high for 80 cycles. A fill_req mid-burst has no effect.
- Fill truncation: fill_addr 0x95F0 → writes 0x95F0..0x95FF only (16 words), then IDLE. fill_addr 0x9600 → no writes.
- Priority mix: FIFO holding one entry, FILL active, and rd_req in the same cycle → grant order read, write, fill over three cycles.
- Range and reset: wr_addr 0x9600 → no mem write, drop = 1. rst asserted mid-fill → all outputs at reset values within the same cycle and no further fill writes.
